digit_scan_mux: RTL
===================

DIGIT_SCAN_MUX -- requirements
Module: digit_scan_mux

Interface
REQ-001 SHALL have parameter DIGITS, default 3, number of 4-bit BCD digits scanned (legal 1..8).
REQ-002 SHALL have parameter PRESCALE, default 4, clock cycles each digit is held (legal 1..65535).
REQ-003 SHALL have parameter LZ_BLANK, default 1: 1 enables leading-zero blanking, 0 disables it.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port load, input, 1 bit: capture bcd_in this cycle.
REQ-007 SHALL have port bcd_in, input, 4*DIGITS bits: digit k at bits [4k+3:4k], digit 0 least significant.
REQ-008 SHALL have port digit_out, output, 4 bits: nibble of the currently scanned digit.
REQ-009 SHALL have port digit_sel, output, DIGITS bits: one-hot enable of the scanned digit, all-zero when blanked.
REQ-010 SHALL have port blank, output, 1 bit: current digit is a suppressed leading zero.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse after each complete scan frame.

Function
REQ-012 SHALL hold internal registers: prescaler pre (0..PRESCALE-1), index idx (0..DIGITS-1), active value act, pending value pend, flag pend_v.
REQ-013 SHALL increment pre every cycle; when pre==PRESCALE-1, set pre to 0 and advance idx by 1.
REQ-014 SHALL wrap idx from DIGITS-1 to 0 (wrap event: pre==PRESCALE-1 and idx==DIGITS-1); one frame = DIGITS*PRESCALE cycles.
REQ-015 SHALL assert frame_done (registered) in exactly the cycle following each wrap event, low otherwise.
REQ-016 SHALL, on load with no wrap event, write bcd_in to pend and set pend_v; act is unchanged (no mid-frame tearing); repeated loads: last wins.
REQ-017 SHALL, on a wrap event, update act to bcd_in if load is high, else to pend if pend_v, else hold act; pend_v cleared in all cases.
REQ-018 SHALL drive digit_out combinationally as act[4*idx+3:4*idx], including non-BCD nibbles (A-F) unchanged.
REQ-019 SHALL drive blank high iff LZ_BLANK==1, idx>0, and every act nibble at positions idx..DIGITS-1 equals 0; digit 0 is never blanked.
REQ-020 SHALL drive digit_sel as one-hot with bit idx set when blank is low, all-zero when blank is high; digit_out still carries the nibble (0) when blanked.
REQ-021 SHALL, with PRESCALE==1, advance idx every cycle; with DIGITS==1, every prescaler terminal count is a wrap event.

Reset
REQ-022 SHALL, while rst is high, force pre=0, idx=0, act=0, pend=0, pend_v=0, frame_done=0, independent of clk.
REQ-023 SHALL present, during and after reset, digit_out=0, digit_sel=1 (bit 0), blank=0.
REQ-024 SHALL discard any pending load when rst asserts mid-frame; the first post-reset frame starts at idx 0, pre 0.

Verification
REQ-025 Defaults; reset, load=1 with bcd_in=12'h255 in the first cycle after reset release (wrap not yet reached) -> act stays 0 (digits 1,2 blanked) until cycle 12; from cycle 12 digits show 5,5,2 each held 4 cycles, digit_sel 001,010,100; frame_done pulses at cycles 12, 24, ...
REQ-026 Defaults; act=12'h007 -> digit 0 shows 7 with digit_sel 001; idx 1,2: blank=1, digit_sel=000; LZ_BLANK=0 -> no blanking, digit_sel 010,100 with digit_out 0.
REQ-027 Defaults; act=12'h205 -> digit 1 (zero, but digit 2 nonzero) not blanked: digit_sel 010, digit_out 0.
REQ-028 Load 12'h111 mid-frame, then load 12'h999 before wrap -> current frame unchanged; next frame shows 9,9,9; load asserted exactly on wrap cycle with 12'h321 -> next frame shows 1,2,3 and pend_v clear.
REQ-029 rst pulsed while idx=2, pend_v=1 -> immediately digit_sel=001, digit_out=0, frame_done=0; pending value never appears.
REQ-030 DIGITS=1, PRESCALE=1; load 4'h8 -> digit_out=8 from next cycle, digit_sel=1 constant, frame_done high every cycle after the first wrap.

Source files
------------

// File: rtl/digit_scan_mux.sv
// Multiplexed BCD display scanner: cycles through DIGITS nibbles, each held for
// PRESCALE clocks, with optional leading-zero blanking and frame-aligned value updates.
module digit_scan_mux #(
    parameter int DIGITS   = 3,
    parameter int PRESCALE = 4,
    parameter int LZ_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [3:0]            digit_out,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  blank,
    output logic                  frame_done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]         pre;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   act;
    logic [4*DIGITS-1:0]   pend;
    logic                  pend_v;
    logic                  pre_tc;
    logic                  wrap;
    logic                  upper_zero;

    assign pre_tc = (pre == PRE_LAST);
    assign wrap   = pre_tc && (idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre        <= '0;
            idx        <= '0;
            act        <= '0;
            pend       <= '0;
            pend_v     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (pre_tc) begin
                pre <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
            // The displayed value only changes at a frame boundary so a frame never tears.
            if (wrap) begin
                if (load) begin
                    act <= bcd_in;
                end else if (pend_v) begin
                    act <= pend;
                end
                pend_v <= 1'b0;
            end else if (load) begin
                pend   <= bcd_in;
                pend_v <= 1'b1;
            end
        end
    end

    always_comb begin
        digit_out  = 4'd0;
        upper_zero = 1'b1;
        blank      = 1'b0;
        digit_sel  = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (IW'(k) == idx) begin
                digit_out = act[4*k +: 4];
            end
            if ((IW'(k) >= idx) && (act[4*k +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
        // Digit 0 is always shown so a zero value still displays "0".
        blank = (LZ_BLANK == 1) && (idx != '0) && upper_zero;
        for (int k = 0; k < DIGITS; k++) begin
            digit_sel[k] = !blank && (IW'(k) == idx);
        end
    end

endmodule
